reg_file_wb_arb: RTL and testbench
==================================

// Module: reg_file_wb_arb
// PURPOSE
//  Write-side driver of the register-file write port (wr_en/wr_reg/wr_data).
//  Arbitrates writeback requests from the ALU and LSU with valid/ready handshakes.
//  Queues accepted writes in a 2-entry FIFO and drives one write per cycle,
//  throttled by wr_ready. Also forwards queued (not yet committed) data onto the
//  two read paths so decode never sees stale operands.
// PARAMETERS
//  QDEPTH  2  pending-write FIFO depth; only 2 is supported (count fits 2 bits)
// PORTS
//  clk           in   1    core clock; all state updates on posedge
//  rst_n         in   1    asynchronous, active-low reset
//  alu_valid     in   1    ALU writeback request
//  alu_rd        in   5    ALU dest reg (rf_addr_t)
//  alu_data      in   32   ALU result (word_t)
//  alu_ready     out  1    ALU request accepted this cycle (valid&&ready)
//  lsu_valid     in   1    LSU writeback request
//  lsu_rd        in   5    LSU dest reg
//  lsu_data      in   32   LSU load data
//  lsu_ready     out  1    LSU request accepted this cycle
//  wr_en         out  1    reg-file write enable (= FIFO non-empty)
//  wr_reg        out  5    reg-file write address (FIFO head)
//  wr_data       out  32   reg-file write data (FIFO head)
//  wr_ready      in   1    reg file accepts write this posedge (0 = port stolen)
//  rd_reg_1      in   5    read address 1 (mirrors reg-file rd_reg_1)
//  rd_reg_2      in   5    read address 2
//  rf_rd_data_1  in   32   raw reg-file read data 1
//  rf_rd_data_2  in   32   raw reg-file read data 2
//  fwd_data_1    out  32   forwarded operand 1
//  fwd_data_2    out  32   forwarded operand 2
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty (count=0, ptrs=0), wr_en=0, wr_reg=X0,
//   wr_data=0, rr pointer = ALU-first. Ready outputs: combinational, per below.
//  Arbitration: one grant per cycle. Single valid -> that source. Both valid ->
//   round-robin; rr toggles only when a contested grant is accepted.
//  Ready: granted source's ready=1 iff count<QDEPTH (no same-cycle pop credit);
//   non-granted source ready=0.
//  x0 requests: if granted and count<QDEPTH -> ready=1, dropped (not queued);
//   this still counts as a contested grant for rr.
//  Push on accepted non-x0 request; pop on wr_en&&wr_ready; push+pop in the
//   same cycle -> count unchanged. Pointers wrap modulo QDEPTH.
//  Latency: request accepted at posedge N -> wr_en=1 with that entry by cycle N+1
//   if FIFO was empty; writes commit in acceptance order.
//  wr_ready=0: head holds, wr_en stays 1; wr_reg/wr_data stable (no change
//   while stalled).
//  Forwarding (combinational): fwd_data_k = youngest queued entry with rd==rd_reg_k,
//   else rf_rd_data_k. rd_reg_k==X0 -> 0 always. Match includes the head, even
//   when it commits this edge.
//  Reset mid-operation: queued writes are discarded, never written.
// STRUCTURE
//  Shared package riscv_32i_defs_pkg: word_t, rf_addr_t, X0 (existing);
//   add wb_req_t {rf_addr_t rd; word_t data;}.
//  One sub-module: wb_fifo (2-entry FIFO, push/pop/count/entry view for forwarding).
//   Arbiter and forwarding muxes live in the top.
// TESTING
//  1 ALU only: alu_rd=5, data=0xDEAD_BEEF, wr_ready=1 -> next cycle wr_en=1,
//    wr_reg=5, wr_data=0xDEADBEEF; FIFO empty after.
//  2 Both valid for 2 cycles (ALU x3=0x11, LSU x4=0x22) from reset -> ALU accepted
//    first, LSU second; writes x3 then x4.
//  3 wr_ready=0 while ALU pushes x1=0xA, x2=0xB -> count=2, alu_ready=0 on third
//    request; wr_ready=1 drains x1, x2 in order.
//  4 Queued x7=0x55 (wr_ready=0), rd_reg_1=7, rf_rd_data_1=0x99 -> fwd_data_1=0x55;
//    queue x7=0x66 too -> fwd_data_1=0x66.
//  5 LSU request to X0 with data 0xFFFF_FFFF -> lsu_ready=1, no wr_en;
//    rd_reg_2=0 -> fwd_data_2=0.
//  6 rst_n low with 2 queued entries -> wr_en=0 immediately (async); no write
//    commits after release.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I definitions: machine word, register-file address, the hard-wired
// zero register, and the writeback request record used by the write-side
// arbiter and its pending-write FIFO.
package riscv_32i_defs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  rf_addr_t;

  localparam rf_addr_t X0 = 5'd0;

  // Pending-write FIFO depth. Only 2 is supported: the count fits 2 bits and
  // the pointers are single bits that wrap naturally.
  localparam int unsigned WB_QDEPTH = 2;

  typedef struct packed {
    rf_addr_t rd;
    word_t    data;
  } wb_req_t;

  // Round-robin preference used only when both sources request together.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/reg_file_wb_arb_wb_fifo.sv
// wb_fifo: 2-entry FIFO of pending register-file writes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       enqueue push_data_i this edge (caller guarantees not full)
//   push_data_i  write to enqueue
//   pop_i        dequeue the head this edge (caller guarantees not empty)
//   count_o      number of queued entries (0..2)
//   full_o       count_o == 2
//   head_o       oldest entry (next write to commit)
//   tail_o       youngest entry (most recent push), valid when count_o != 0
module wb_fifo
  import riscv_32i_defs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  wb_req_t    push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output logic       full_o,
  output wb_req_t    head_o,
  output wb_req_t    tail_o
);

  localparam logic [1:0] FULL_CNT = 2'(WB_QDEPTH);

  wb_req_t    mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_i  ? ~rd_ptr_q : rd_ptr_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // when count_q says the slot is live, so reset flops would be pure cost.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = mem_q[~wr_ptr_q];

endmodule

// File: rtl/reg_file_wb_arb.sv
// reg_file_wb_arb: write-side driver of the register-file write port.
// Arbitrates ALU/LSU writeback requests (valid/ready, round-robin when both
// request), queues accepted writes in wb_fifo, presents the FIFO head on the
// write port (one commit per cycle, stalled by wr_ready), and forwards queued
// data onto both read paths so decode never sees stale operands.
// Ports:
//   alu_valid/alu_rd/alu_data, alu_ready   ALU writeback request/accept
//   lsu_valid/lsu_rd/lsu_data, lsu_ready   LSU writeback request/accept
//   wr_en/wr_reg/wr_data, wr_ready         register-file write port
//   rd_reg_k, rf_rd_data_k, fwd_data_k     read path k (k=1,2) forwarding
module reg_file_wb_arb
  import riscv_32i_defs_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     alu_valid,
  input  rf_addr_t alu_rd,
  input  word_t    alu_data,
  output logic     alu_ready,
  input  logic     lsu_valid,
  input  rf_addr_t lsu_rd,
  input  word_t    lsu_data,
  output logic     lsu_ready,
  output logic     wr_en,
  output rf_addr_t wr_reg,
  output word_t    wr_data,
  input  logic     wr_ready,
  input  rf_addr_t rd_reg_1,
  input  rf_addr_t rd_reg_2,
  input  word_t    rf_rd_data_1,
  input  word_t    rf_rd_data_2,
  output word_t    fwd_data_1,
  output word_t    fwd_data_2
);

  rr_sel_e    rr_q, rr_d;
  logic       grant_alu, grant_lsu, accept, push, pop, full;
  logic [1:0] count;
  wb_req_t    req, head, tail;

  // Youngest queued write to rd wins; with one entry head and tail coincide.
  // The head still forwards while it commits, since the reg file only sees the
  // new value after this edge.
  function automatic word_t fwd_sel(input rf_addr_t rd, input word_t rf_data,
                                    input logic [1:0] cnt, input wb_req_t hd,
                                    input wb_req_t tl);
    word_t res;
    res = rf_data;
    if (rd == X0)                        res = '0;
    else if (cnt != 2'd0 && tl.rd == rd) res = tl.data;
    else if (cnt == 2'd2 && hd.rd == rd) res = hd.data;
    return res;
  endfunction

  // NOTE: every signal in this block gets a default before any branch so no
  // path leaves one unassigned and infers a latch.
  always_comb begin
    grant_alu = alu_valid && (!lsu_valid || rr_q == RR_ALU);
    grant_lsu = lsu_valid && (!alu_valid || rr_q == RR_LSU);
    // No pop credit: a full FIFO refuses even if the head commits this edge.
    alu_ready = grant_alu && !full;
    lsu_ready = grant_lsu && !full;
    accept    = alu_ready || lsu_ready;
    req       = grant_alu ? wb_req_t'{rd: alu_rd, data: alu_data}
                          : wb_req_t'{rd: lsu_rd, data: lsu_data};
    // X0 writes are accepted and dropped; they still count for round-robin.
    push      = accept && (req.rd != X0);
    pop       = wr_en && wr_ready;
    rr_d      = rr_q;
    if (alu_valid && lsu_valid && accept)
      rr_d = (rr_q == RR_ALU) ? RR_LSU : RR_ALU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= RR_ALU;
    else        rr_q <= rr_d;
  end

  wb_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (req),
    .pop_i       (pop),
    .count_o     (count),
    .full_o      (full),
    .head_o      (head),
    .tail_o      (tail)
  );

  // Head is gated so the port idles at X0/0 when nothing is queued.
  assign wr_en   = (count != 2'd0);
  assign wr_reg  = wr_en ? head.rd   : X0;
  assign wr_data = wr_en ? head.data : '0;

  assign fwd_data_1 = fwd_sel(rd_reg_1, rf_rd_data_1, count, head, tail);
  assign fwd_data_2 = fwd_sel(rd_reg_2, rf_rd_data_2, count, head, tail);

endmodule

// File: tb/tb_reg_file_wb_arb.sv
// Bench for reg_file_wb_arb. Inputs change 1ns after posedge; outputs are
// sampled on negedge. Expected commits are queued when a request is driven
// that must be accepted, and popped whenever the write port commits.
module tb_reg_file_wb_arb;
  import riscv_32i_defs_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     alu_valid, lsu_valid, alu_ready, lsu_ready;
  rf_addr_t alu_rd, lsu_rd, wr_reg, rd_reg_1, rd_reg_2;
  word_t    alu_data, lsu_data, wr_data;
  word_t    rf_rd_data_1, rf_rd_data_2, fwd_data_1, fwd_data_2;
  logic     wr_en, wr_ready;

  int      errors = 0;
  int      checks = 0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_wb_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .wr_en        (wr_en),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_reg_1     (rd_reg_1),
    .rd_reg_2     (rd_reg_2),
    .rf_rd_data_1 (rf_rd_data_1),
    .rf_rd_data_2 (rf_rd_data_2),
    .fwd_data_1   (fwd_data_1),
    .fwd_data_2   (fwd_data_2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = X0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = X0; lsu_data = '0;
  endtask

  // Advance to negedge and score any commit that the coming posedge performs.
  task automatic sample();
    wb_req_t e;
    @(negedge clk);
    if (rst_n && wr_en && wr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got x%0d=%h, required no write", wr_reg, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_reg !== e.rd || wr_data !== e.data) begin
          errors++;
          $display("FAIL commit_order: got x%0d=%h, required x%0d=%h", wr_reg, wr_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); wr_ready = 1'b1;
    rd_reg_1 = 5'd1; rd_reg_2 = 5'd2; rf_rd_data_1 = 32'h1; rf_rd_data_2 = 32'h2;
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
    #3;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
    checks++; if (wr_reg !== X0) begin errors++; $display("FAIL rst_wr_reg: got %0d, required 0", wr_reg); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data: got %h, required 0", wr_data); end
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rst_rr_alu_first: got alu=%b lsu=%b, required alu=1 lsu=0", alu_ready, lsu_ready);
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_single();
    wr_ready = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    sample();
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL t1_alu_ready: got %b, required 1", alu_ready); end
    exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    cyc(); idle();
    sample();
    checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL t1_write: got en=%b x%0d=%h, required en=1 x5=deadbeef", wr_en, wr_reg, wr_data);
    end
    cyc(); sample();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t1_empty: got wr_en=%b, required 0", wr_en); end
    cyc();
  endtask

  task automatic test_both_rr();
    wr_ready = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    sample();
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL t2_grant1: got alu=%b lsu=%b, required alu=1 lsu=0", alu_ready, lsu_ready);
    end
    exp_q.push_back('{rd: 5'd3, data: 32'h11});
    cyc(); sample();
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++; $display("FAIL t2_grant2: got alu=%b lsu=%b, required alu=0 lsu=1", alu_ready, lsu_ready);
    end
    exp_q.push_back('{rd: 5'd4, data: 32'h22});
    checks++; if (wr_reg !== 5'd3) begin errors++; $display("FAIL t2_first_write: got x%0d, required x3", wr_reg); end
    cyc(); idle(); sample();
    checks++; if (wr_reg !== 5'd4 || wr_data !== 32'h22) begin
      errors++; $display("FAIL t2_second_write: got x%0d=%h, required x4=22", wr_reg, wr_data);
    end
    cyc(); sample();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t2_empty: got wr_en=%b, required 0", wr_en); end
    cyc();
  endtask

  task automatic test_stall();
    wr_ready = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    sample();
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL t3_push1: got %b, required 1", alu_ready); end
    exp_q.push_back('{rd: 5'd1, data: 32'hA});
    cyc(); alu_rd = 5'd2; alu_data = 32'hB;
    sample();
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL t3_push2: got %b, required 1", alu_ready); end
    exp_q.push_back('{rd: 5'd2, data: 32'hB});
    cyc(); alu_rd = 5'd9; alu_data = 32'hC;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL t3_full_refuse: got %b, required 0", alu_ready); end
      checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd1 || wr_data !== 32'hA) begin
        errors++; $display("FAIL t3_stall_hold: got en=%b x%0d=%h, required en=1 x1=a", wr_en, wr_reg, wr_data);
      end
      cyc();
    end
    idle(); wr_ready = 1'b1;
    sample(); cyc();
    sample();
    checks++; if (wr_reg !== 5'd2 || wr_data !== 32'hB) begin
      errors++; $display("FAIL t3_drain2: got x%0d=%h, required x2=b", wr_reg, wr_data);
    end
    cyc(); sample();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t3_empty: got wr_en=%b, required 0", wr_en); end
    cyc();
  endtask

  task automatic test_forward();
    wr_ready = 1'b0;
    rd_reg_1 = 5'd7; rf_rd_data_1 = 32'h99;
    rd_reg_2 = 5'd8; rf_rd_data_2 = 32'h77;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
    sample();
    checks++; if (fwd_data_1 !== 32'h99) begin errors++; $display("FAIL t4_fwd_none: got %h, required 99", fwd_data_1); end
    exp_q.push_back('{rd: 5'd7, data: 32'h55});
    cyc(); alu_data = 32'h66;
    sample();
    checks++; if (fwd_data_1 !== 32'h55) begin errors++; $display("FAIL t4_fwd_one: got %h, required 55", fwd_data_1); end
    exp_q.push_back('{rd: 5'd7, data: 32'h66});
    cyc(); idle();
    sample();
    checks++; if (fwd_data_1 !== 32'h66) begin errors++; $display("FAIL t4_fwd_young: got %h, required 66", fwd_data_1); end
    checks++; if (fwd_data_2 !== 32'h77) begin errors++; $display("FAIL t4_fwd_miss: got %h, required 77", fwd_data_2); end
    cyc(); wr_ready = 1'b1;
    sample(); cyc();
    sample();
    checks++; if (fwd_data_1 !== 32'h66) begin errors++; $display("FAIL t4_fwd_head_commit: got %h, required 66", fwd_data_1); end
    cyc(); sample();
    checks++; if (fwd_data_1 !== 32'h99) begin errors++; $display("FAIL t4_fwd_drained: got %h, required 99", fwd_data_1); end
    cyc();
  endtask

  task automatic test_x0();
    wr_ready = 1'b1;
    rd_reg_2 = X0; rf_rd_data_2 = 32'hDEAD;
    lsu_valid = 1'b1; lsu_rd = X0; lsu_data = 32'hFFFF_FFFF;
    sample();
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL t5_x0_ready: got %b, required 1", lsu_ready); end
    checks++; if (fwd_data_2 !== 32'h0) begin errors++; $display("FAIL t5_fwd_x0: got %h, required 0", fwd_data_2); end
    cyc(); idle(); sample();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t5_x0_dropped: got wr_en=%b, required 0", wr_en); end
    cyc();
    // Contested X0 grant must still advance round-robin.
    alu_valid = 1'b1; alu_rd = X0; alu_data = 32'h5;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
    sample();
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL t5_x0_grant: got alu=%b lsu=%b, required alu=1 lsu=0", alu_ready, lsu_ready);
    end
    cyc(); sample();
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++; $display("FAIL t5_rr_after_x0: got alu=%b lsu=%b en=%b, required alu=0 lsu=1 en=0", alu_ready, lsu_ready, wr_en);
    end
    exp_q.push_back('{rd: 5'd6, data: 32'h66});
    cyc(); idle(); sample(); cyc(); sample();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t5_empty: got wr_en=%b, required 0", wr_en); end
    cyc();
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1;
    sample(); cyc();
    alu_rd = 5'd11; alu_data = 32'h2;
    sample(); cyc(); idle();
    sample();
    checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd10) begin
      errors++; $display("FAIL t6_queued: got en=%b x%0d, required en=1 x10", wr_en, wr_reg);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_reg !== X0 || wr_data !== 32'h0) begin
      errors++; $display("FAIL t6_async_clear: got en=%b x%0d=%h, required en=0 x0=0", wr_en, wr_reg, wr_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t6_no_commit: got wr_en=%b, required 0", wr_en); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_both_rr();
    test_stall();
    test_forward();
    test_x0();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
